sfx_sequencer: RTL and testbench

- Sits directly upstream of the pong sound generator.
- Converts raw game events (paddle hit, wall bounce, miss/score) into the generator's trigger interface: a one-cycle strobe `c` plus effect select `fxa` and long-duration flag `fxb`.
- Queues events, arbitrates by priority, and enforces a hold-off so a new trigger never cuts a running effect short, except that a miss preempts short effects.
- Runs on the same ~134 kHz sound clock as the generator.

---
 rtl/sfx_pkg.sv | 30 +++
 rtl/sfx_event_latch.sv | 55 +++++
 rtl/sfx_sequencer.sv | 111 +++++++++++
 tb/tb_sfx_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect sequencer and the pong sound generator.
// Effect codes and duration flags live here so both sides agree on encodings.
package sfx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FIRE  = 2'd2,
    HOLD  = 2'd3
  } sfx_state_t;

  localparam logic [3:0] FX_PADDLE = 4'd0;
  localparam logic [3:0] FX_WALL   = 4'd1;
  localparam logic [3:0] FX_MISS   = 4'd2;

  localparam logic DUR_SHORT = 1'b0;
  localparam logic DUR_LONG  = 1'b1;

  typedef struct packed {
    logic miss;
    logic paddle;
    logic wall;
  } sfx_pend_t;

  // Only the miss whistle uses the long generator duration.
  function automatic logic fx_duration(input logic [3:0] fx);
    return (fx == FX_MISS) ? DUR_LONG : DUR_SHORT;
  endfunction

endpackage

// File: rtl/sfx_event_latch.sv
// Pending-event flags for paddle/wall/miss with set-wins-over-clear, mute flush,
// and a miss > paddle > wall priority encoder.
module sfx_event_latch
  import sfx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ev_paddle,
  input  logic       ev_wall,
  input  logic       ev_miss,
  input  logic       mute,
  input  sfx_pend_t  clr,
  output logic       any_pending,
  output logic       miss_pending,
  output logic [3:0] win_fx,
  output logic       win_long,
  output sfx_pend_t  win_clr
);

  sfx_pend_t pend;

  // A set on the same edge as a clear keeps the flag; repeats simply merge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
    end else if (mute) begin
      pend <= '0;
    end else begin
      pend.miss   <= ev_miss   | (pend.miss   & ~clr.miss);
      pend.paddle <= ev_paddle | (pend.paddle & ~clr.paddle);
      pend.wall   <= ev_wall   | (pend.wall   & ~clr.wall);
    end
  end

  // A winning miss also discards stale paddle/wall sounds.
  always_comb begin
    win_fx  = FX_PADDLE;
    win_clr = '0;
    if (pend.miss) begin
      win_fx  = FX_MISS;
      win_clr = '{miss: 1'b1, paddle: 1'b1, wall: 1'b1};
    end else if (pend.paddle) begin
      win_fx         = FX_PADDLE;
      win_clr.paddle = 1'b1;
    end else if (pend.wall) begin
      win_fx       = FX_WALL;
      win_clr.wall = 1'b1;
    end
    win_long = fx_duration(win_fx);
  end

  assign any_pending  = pend.miss | pend.paddle | pend.wall;
  assign miss_pending = pend.miss;

endmodule

// File: rtl/sfx_sequencer.sv
// Turns game events into one-cycle triggers for the pong sound generator,
// holding off new triggers until the running effect finishes (miss may preempt short ones).
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int HOLD_SHORT = 4096,
  parameter int HOLD_LONG  = 32767,
  parameter int CW         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ev_paddle,
  input  logic       ev_wall,
  input  logic       ev_miss,
  input  logic       mute,
  output logic       c,
  output logic [3:0] fxa,
  output logic       fxb,
  output logic       busy
);

  localparam logic [CW-1:0] LOAD_SHORT = CW'(HOLD_SHORT);
  localparam logic [CW-1:0] LOAD_LONG  = CW'(HOLD_LONG);

  if ((64'd1 << CW) <= 64'(((HOLD_SHORT > HOLD_LONG) ? HOLD_SHORT : HOLD_LONG) + 1)) begin : g_cw_check
    $error("sfx_sequencer: CW too narrow for the hold durations");
  end

  sfx_state_t    state;
  logic [CW-1:0] cnt;
  sfx_pend_t     clr;
  sfx_pend_t     win_clr;
  logic          any_pending;
  logic          miss_pending;
  logic [3:0]    win_fx;
  logic          win_long;
  logic          take;

  sfx_event_latch u_latch (
    .clk          (clk),
    .reset        (reset),
    .ev_paddle    (ev_paddle),
    .ev_wall      (ev_wall),
    .ev_miss      (ev_miss),
    .mute         (mute),
    .clr          (clr),
    .any_pending  (any_pending),
    .miss_pending (miss_pending),
    .win_fx       (win_fx),
    .win_long     (win_long),
    .win_clr      (win_clr)
  );

  // take: the winner is accepted this cycle and its code loads on the next edge.
  always_comb begin
    take = 1'b0;
    if (!mute) begin
      case (state)
        IDLE:    take = any_pending;
        HOLD:    take = (fxb == DUR_SHORT) && miss_pending;
        default: take = 1'b0;
      endcase
    end
    clr = take ? win_clr : '0;
  end

  // c is a plain register so the generator's asynchronous load never sees a glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      c     <= 1'b0;
      fxa   <= FX_PADDLE;
      fxb   <= DUR_SHORT;
    end else begin
      c <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            state <= SETUP;
            fxa   <= win_fx;
            fxb   <= win_long;
          end
        end
        SETUP: begin
          state <= FIRE;
          c     <= 1'b1;
        end
        FIRE: begin
          state <= HOLD;
          cnt   <= (fxb == DUR_LONG) ? LOAD_LONG : LOAD_SHORT;
        end
        HOLD: begin
          if (take) begin
            state <= SETUP;
            fxa   <= win_fx;
            fxb   <= win_long;
          end else if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: directed scenarios plus random events, all compared
// cycle by cycle against a timeline model of triggers and hold windows.
module tb_sfx_sequencer;

  localparam int HS = 16;
  localparam int HL = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       ev_paddle;
  logic       ev_wall;
  logic       ev_miss;
  logic       mute;
  logic       c;
  logic [3:0] fxa;
  logic       fxb;
  logic       busy;

  always #5 clk = ~clk;

  sfx_sequencer #(.HOLD_SHORT(HS), .HOLD_LONG(HL), .CW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .ev_paddle (ev_paddle),
    .ev_wall   (ev_wall),
    .ev_miss   (ev_miss),
    .mute      (mute),
    .c         (c),
    .fxa       (fxa),
    .fxb       (fxb),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Timeline model: pending set, when the next trigger fires, when the block is idle again.
  logic       m_paddle, m_wall, m_miss;
  logic       m_long;
  logic [3:0] m_fxa;
  logic       m_fxb;
  int         t;
  int         fire_t;
  int         idle_at;
  logic [4:0] exp_q[$];
  int         c_hits[$];
  int         last_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    m_paddle  = 1'b0;
    m_wall    = 1'b0;
    m_miss    = 1'b0;
    m_long    = 1'b0;
    m_fxa     = 4'd0;
    m_fxb     = 1'b0;
    t         = 0;
    fire_t    = -100;
    idle_at   = 0;
    last_busy = -1;
    exp_q.delete();
    c_hits.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    ev_paddle = 1'b0; ev_wall = 1'b0; ev_miss = 1'b0; mute = 1'b0;
    #1;
    check_eq("rst_c", 32'(c), 0);
    check_eq("rst_fxa", 32'(fxa), 0);
    check_eq("rst_fxb", 32'(fxb), 0);
    check_eq("rst_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One cycle: drive inputs, compare outputs at the falling edge, then advance the model.
  task automatic tick(input logic p, input logic w, input logic m, input logic mu);
    logic       in_idle, in_hold, take_m, lng, cp, cw, cm;
    logic [3:0] code;
    logic [4:0] exp;
    @(posedge clk);
    #1;
    ev_paddle = p; ev_wall = w; ev_miss = m; mute = mu;
    @(negedge clk);
    check_eq("c", 32'(c), 32'(t == fire_t));
    check_eq("busy", 32'(busy), 32'(t < idle_at));
    check_eq("fxa", 32'(fxa), 32'(m_fxa));
    check_eq("fxb", 32'(fxb), 32'(m_fxb));
    if (busy === 1'b1) last_busy = t;
    if (c === 1'b1) begin
      c_hits.push_back(t);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check_eq("trig_code", {27'd0, fxa, fxb}, {27'd0, exp});
      end else begin
        check_eq("trig_spurious", 32'(c), 0);
      end
    end
    in_idle = (t >= idle_at);
    in_hold = (t > fire_t) && (t < idle_at);
    take_m  = !mu && ((in_idle && (m_paddle || m_wall || m_miss)) ||
                      (in_hold && !m_long && m_miss));
    cp = 1'b0; cw = 1'b0; cm = 1'b0; code = 4'd0; lng = 1'b0;
    if (take_m) begin
      if (m_miss) begin
        code = 4'd2; lng = 1'b1; cp = 1'b1; cw = 1'b1; cm = 1'b1;
      end else if (m_paddle) begin
        code = 4'd0; cp = 1'b1;
      end else begin
        code = 4'd1; cw = 1'b1;
      end
      fire_t  = t + 2;
      idle_at = t + 4 + (lng ? HL : HS);
      m_long  = lng;
      m_fxa   = code;
      m_fxb   = lng;
      exp_q.push_back({code, lng});
    end
    m_paddle = mu ? 1'b0 : (p | (m_paddle & ~cp));
    m_wall   = mu ? 1'b0 : (w | (m_wall & ~cw));
    m_miss   = mu ? 1'b0 : (m | (m_miss & ~cm));
    t++;
  endtask

  task automatic run_scn(input int id, input int len);
    logic p, w, m, mu;
    for (int i = 0; i < len; i++) begin
      p = 1'b0; w = 1'b0; m = 1'b0; mu = 1'b0;
      case (id)
        1: p = (i == 10);
        2: begin p = (i == 10); w = (i == 10); end
        3: begin w = (i == 10); m = (i == 20); p = (i == 20); end
        4: w = (i == 10) || (i == 20) || (i == 25) || (i == 28);
        5: begin mu = (i >= 5) && (i <= 30); p = (i == 10); m = (i == 12); end
        6: m = (i == 10);
        default: ;
      endcase
      tick(p, w, m, mu);
      if (id == 5 && i == 15) check_eq("s5_flags", 32'(dut.u_latch.pend), 0);
    end
  endtask

  function automatic int hit(input int idx);
    return (c_hits.size() > idx) ? c_hits[idx] : -1;
  endfunction

  initial begin
    reset = 1'b1;
    ev_paddle = 1'b0; ev_wall = 1'b0; ev_miss = 1'b0; mute = 1'b0;

    // Single paddle hit.
    do_reset();
    run_scn(1, 40);
    check_eq("s1_ntrig", c_hits.size(), 1);
    check_eq("s1_c_cycle", hit(0), 13);
    check_eq("s1_busy_last", last_busy, 30);
    check_eq("s1_drain", exp_q.size(), 0);

    // Paddle and wall together: paddle first, wall HS+4 later.
    do_reset();
    run_scn(2, 60);
    check_eq("s2_ntrig", c_hits.size(), 2);
    check_eq("s2_c0", hit(0), 13);
    check_eq("s2_c1", hit(1), 33);
    check_eq("s2_drain", exp_q.size(), 0);

    // Miss sampled at the end of cycle 20 is decided in 21, so FIRE lands on 23;
    // the paddle sampled on that same edge is wiped by the miss win.
    do_reset();
    run_scn(3, 110);
    check_eq("s3_ntrig", c_hits.size(), 2);
    check_eq("s3_c0", hit(0), 13);
    check_eq("s3_c1", hit(1), 23);
    check_eq("s3_busy_last", last_busy, 88);
    check_eq("s3_drain", exp_q.size(), 0);

    // Repeated walls during a hold merge into one extra trigger.
    do_reset();
    run_scn(4, 60);
    check_eq("s4_ntrig", c_hits.size(), 2);
    check_eq("s4_c0", hit(0), 13);
    check_eq("s4_c1", hit(1), 33);

    // Events under mute are dropped and do not fire once mute is released.
    do_reset();
    run_scn(5, 70);
    check_eq("s5_ntrig", c_hits.size(), 0);

    // Async reset in the middle of a miss hold.
    do_reset();
    run_scn(6, 41);
    check_eq("s6_pre_busy", 32'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("s6_rst_c", 32'(c), 0);
    check_eq("s6_rst_fxa", 32'(fxa), 0);
    check_eq("s6_rst_fxb", 32'(fxb), 0);
    check_eq("s6_rst_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    run_scn(0, 100);
    check_eq("s6_ntrig", c_hits.size(), 0);

    // Random events with occasional mute, then a quiet drain.
    do_reset();
    begin
      logic mu_r;
      mu_r = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 199) == 0) mu_r = ~mu_r;
        tick($urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0,
             $urandom_range(0, 59) == 0, mu_r);
      end
      for (int i = 0; i < 200; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_eq("rnd_drain", exp_q.size(), 0);
    check_eq("rnd_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
